// File: rtl/codec_clk_pkg.sv
// Shared types and constants for the codec clock scheduler: rate table,
// state encoding and half-period width.
package codec_clk_pkg;

    localparam int H_W = 6;

    typedef logic [H_W-1:0] half_t;
    typedef logic [1:0]     rate_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Half-period in main_clock cycles, indexed by rate select (entry 0 is rightmost).
    localparam logic [3:0][H_W-1:0] HALF_TABLE = {6'd4, 6'd49, 6'd12, 6'd8};

    function automatic half_t half_period(input rate_sel_t sel);
        return HALF_TABLE[sel];
    endfunction

endpackage

// File: rtl/half_period_counter.sv
// Loadable half-period divider: counts 0..H-1, toggles bclk at H-1 and
// produces registered rise/fall strobes aligned with the new bclk value.
module half_period_counter
    import codec_clk_pkg::*;
#(
    parameter half_t H_RESET = 6'd8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  run,
    input  logic  load,
    input  half_t h,
    output logic  bclk_o,
    output logic  rise_stb_o,
    output logic  fall_stb_o,
    output logic  fall_tick_o
);

    half_t h_q, h_d;
    half_t hcnt_q, hcnt_d;
    half_t h_last;
    logic  bclk_q, bclk_d;
    logic  rise_q, rise_d;
    logic  fall_q, fall_d;
    logic  tick;

    assign h_last      = h_q - half_t'(1);
    assign tick        = run && (hcnt_q == h_last);
    // Combinational look-ahead: the current cycle ends with a bclk falling toggle.
    assign fall_tick_o = tick && bclk_q;

    // NOTE: every _d gets a default before any branch, so no path leaves a latch.
    always_comb begin
        h_d    = h_q;
        hcnt_d = hcnt_q;
        bclk_d = bclk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        if (!run) begin
            hcnt_d = '0;
            bclk_d = 1'b0;
        end else if (tick) begin
            hcnt_d = '0;
            bclk_d = ~bclk_q;
            rise_d = ~bclk_q;
            fall_d = bclk_q;
        end else begin
            hcnt_d = hcnt_q + half_t'(1);
        end

        // Loads only arrive at a toggle or while stopped, so the restart never cuts a half-period.
        if (load) begin
            h_d    = h;
            hcnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q    <= H_RESET;
            hcnt_q <= '0;
            bclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            hcnt_q <= hcnt_d;
            bclk_q <= bclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;

endmodule

// File: rtl/codec_clk_sched.sv
// Codec clock scheduler: run/stop FSM, frame bit counter, LRCK and the
// rate-change request latch that retimes H changes to frame boundaries.
module codec_clk_sched
    import codec_clk_pkg::*;
#(
    parameter int        FRAME_BITS  = 64,
    parameter rate_sel_t DEFAULT_SEL = 2'd0
) (
    input  logic       main_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       rate_req,
    output logic       rate_ack,
    output logic       busy,
    output logic       running,
    output logic       bclk,
    output logic       lrck,
    output logic       bclk_rise_stb,
    output logic       bclk_fall_stb,
    output logic       frame_start
);

    localparam int    BIT_W   = $clog2(FRAME_BITS);
    localparam half_t H_RESET = HALF_TABLE[DEFAULT_SEL];

    typedef logic [BIT_W-1:0] bit_t;

    localparam bit_t LAST_BIT = bit_t'(FRAME_BITS - 1);
    localparam bit_t HALF_BIT = bit_t'(FRAME_BITS / 2);

    state_e    state_q, state_d;
    bit_t      bit_cnt_q, bit_cnt_d;
    logic      lrck_q, lrck_d;
    logic      frame_start_q, frame_start_d;
    logic      busy_q, busy_d;
    logic      rate_ack_q, rate_ack_d;
    rate_sel_t pend_sel_q, pend_sel_d;

    logic  div_run;
    logic  fall_tick;
    logic  wrap;
    logic  stop;
    logic  apply;
    half_t pend_h;

    assign div_run = (state_q != ST_IDLE);
    assign wrap    = fall_tick && (bit_cnt_q == LAST_BIT);
    assign stop    = (state_q == ST_STOPPING) && !enable && wrap;
    // A latched request lands immediately when stopped, otherwise at the frame boundary.
    assign apply   = busy_q && ((state_q == ST_IDLE) || wrap);
    assign pend_h  = half_period(pend_sel_q);

    half_period_counter #(
        .H_RESET (H_RESET)
    ) u_hcnt (
        .clk_i       (main_clock),
        .rst_i       (reset),
        .run         (div_run),
        .load        (apply),
        .h           (pend_h),
        .bclk_o      (bclk),
        .rise_stb_o  (bclk_rise_stb),
        .fall_stb_o  (bclk_fall_stb),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (enable) state_d = ST_RUN;
            ST_RUN:      if (!enable) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (enable)    state_d = ST_RUN;
                else if (wrap) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        lrck_d        = lrck_q;
        frame_start_d = 1'b0;
        busy_d        = busy_q;
        pend_sel_d    = pend_sel_q;
        rate_ack_d    = apply;

        if ((state_q == ST_IDLE) || stop) begin
            bit_cnt_d = '0;
            lrck_d    = 1'b0;
        end else if (fall_tick) begin
            bit_cnt_d     = wrap ? '0 : bit_cnt_q + bit_t'(1);
            lrck_d        = (bit_cnt_d >= HALF_BIT);
            frame_start_d = wrap;
        end

        // Uses the registered busy, so a request in the boundary cycle waits a full frame.
        if (apply) begin
            busy_d = 1'b0;
        end else if (rate_req && !busy_q) begin
            busy_d     = 1'b1;
            pend_sel_d = rate_sel;
        end
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            lrck_q        <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            rate_ack_q    <= 1'b0;
            pend_sel_q    <= DEFAULT_SEL;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            lrck_q        <= lrck_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            rate_ack_q    <= rate_ack_d;
            pend_sel_q    <= pend_sel_d;
        end
    end

    assign running     = div_run;
    assign lrck        = lrck_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign rate_ack    = rate_ack_q;

endmodule

// File: tb/tb_codec_clk_sched.sv
// Bench for codec_clk_sched: a position-in-frame model checked every cycle,
// plus directed timing checks with hand-computed cycle distances.
module tb_codec_clk_sched;

    localparam int FB = 64;

    localparam int S_RUN  = 0;
    localparam int S_RISE = 1;
    localparam int S_FS   = 2;
    localparam int S_ACK  = 3;
    localparam int S_LRCK = 4;
    localparam int S_IDLE = 5;

    logic       main_clock;
    logic       reset;
    logic       enable;
    logic [1:0] rate_sel;
    logic       rate_req;
    logic       rate_ack;
    logic       busy;
    logic       running;
    logic       bclk;
    logic       lrck;
    logic       bclk_rise_stb;
    logic       bclk_fall_stb;
    logic       frame_start;
    logic [7:0] dut_v;

    int n_tests;
    int n_fail;
    int cyc;
    int ack_count;

    typedef struct {
        int         st;
        int         pos;
        int         h;
        int         pend;
        bit         busy;
        logic [7:0] outv;
    } model_t;

    model_t m;

    codec_clk_sched #(
        .FRAME_BITS  (FB),
        .DEFAULT_SEL (2'd0)
    ) dut (
        .main_clock    (main_clock),
        .reset         (reset),
        .enable        (enable),
        .rate_sel      (rate_sel),
        .rate_req      (rate_req),
        .rate_ack      (rate_ack),
        .busy          (busy),
        .running       (running),
        .bclk          (bclk),
        .lrck          (lrck),
        .bclk_rise_stb (bclk_rise_stb),
        .bclk_fall_stb (bclk_fall_stb),
        .frame_start   (frame_start)
    );

    assign dut_v = {rate_ack, busy, running, bclk, lrck, bclk_rise_stb, bclk_fall_stb, frame_start};

    initial begin
        main_clock = 1'b0;
        forever #5 main_clock = ~main_clock;
    end

    initial begin
        cyc = 0;
        forever @(posedge main_clock) cyc++;
    end

    function automatic int tbl(input int s);
        case (s)
            0:       return 8;
            1:       return 12;
            2:       return 49;
            default: return 4;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.st   = 0;
        r.pos  = 0;
        r.h    = tbl(0);
        r.pend = 0;
        r.busy = 1'b0;
        r.outv = '0;
        return r;
    endfunction

    // pos = cycles since the current frame began (or since entering RUN).
    function automatic model_t model_next(input model_t c, input bit en, input bit req,
                                          input logic [1:0] sel);
        model_t n;
        int     period;
        int     hp;
        bit     wrap, apply, stop;
        bit     o_bclk, o_lrck, o_rise, o_fall, o_fs;
        n      = c;
        period = FB * 2 * c.h;
        wrap   = (c.st != 0) && (c.pos == period - 1);
        apply  = c.busy && ((c.st == 0) || wrap);
        stop   = (c.st == 2) && !en && wrap;
        if (apply) begin
            n.busy = 1'b0;
            n.h    = tbl(c.pend);
        end else if (req && !c.busy) begin
            n.busy = 1'b1;
            n.pend = int'(sel);
        end
        case (c.st)
            0:       n.st = en ? 1 : 0;
            1:       n.st = en ? 1 : 2;
            default: n.st = en ? 1 : (wrap ? 0 : 2);
        endcase
        n.pos = ((c.st == 0) || wrap) ? 0 : c.pos + 1;
        hp    = 2 * n.h;
        if ((c.st == 0) || stop) begin
            o_bclk = 1'b0;
            o_lrck = 1'b0;
            o_rise = 1'b0;
            o_fall = stop;
            o_fs   = 1'b0;
        end else begin
            o_bclk = (n.pos % hp) >= n.h;
            o_lrck = (n.pos / hp) >= FB / 2;
            o_rise = (n.pos % hp) == n.h;
            o_fall = wrap || ((n.pos % hp) == 0 && n.pos != 0);
            o_fs   = wrap;
        end
        n.outv = {apply, n.busy, n.st != 0, o_bclk, o_lrck, o_rise, o_fall, o_fs};
        return n;
    endfunction

    initial begin
        m = model_reset();
        forever begin
            @(posedge main_clock or posedge reset);
            if (reset) m = model_reset();
            else       m = model_next(m, enable, rate_req, rate_sel);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge main_clock);
            if (!reset) begin
                check($sformatf("outputs{ack,busy,run,bclk,lrck,rise,fall,fs} cyc %0d", cyc),
                      32'(dut_v), 32'(m.outv));
                if (rate_ack) ack_count++;
            end
        end
    end

    function automatic bit sig(input int which);
        case (which)
            S_RUN:   return running;
            S_RISE:  return bclk_rise_stb;
            S_FS:    return frame_start;
            S_ACK:   return rate_ack;
            S_LRCK:  return lrck;
            default: return !running;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge main_clock);
            if (sig(which)) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_for(%0d): no event within %0d cycles", which, budget);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge main_clock);
    endtask

    initial begin
        int t_run, t_r1, t_r2, t_fs, t_fs2, t_lr, t_ack, t_idle;
        n_tests   = 0;
        n_fail    = 0;
        ack_count = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        rate_req  = 1'b0;
        rate_sel  = 2'd0;

        // Reset state
        tick(3);
        #1;
        check("reset_outputs", 32'(dut_v), 32'h0);

        // sel 0: H=8, BCLK 16 cycles, frame 1024 cycles
        @(negedge main_clock);
        reset  = 1'b0;
        enable = 1'b1;
        wait_for(S_RUN, 5, t_run);
        wait_for(S_RISE, 20, t_r1);
        check("first_rise_sel0", 32'(t_r1 - t_run), 32'd8);
        wait_for(S_RISE, 20, t_r2);
        check("bclk_period_sel0", 32'(t_r2 - t_r1), 32'd16);
        wait_for(S_FS, 1100, t_fs);
        check("first_frame_start", 32'(t_fs - t_run), 32'd1024);
        wait_for(S_LRCK, 600, t_lr);
        check("lrck_right_slot", 32'(t_lr - t_fs), 32'd512);
        wait_for(S_FS, 1100, t_fs2);
        check("frame_period_sel0", 32'(t_fs2 - t_fs), 32'd1024);

        // Request sel 3 at bit 10, then a sel 2 request while busy
        tick(165);
        ack_count = 0;
        rate_sel  = 2'd3;
        rate_req  = 1'b1;
        @(negedge main_clock);
        rate_req  = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
        tick(3);
        rate_sel  = 2'd2;
        rate_req  = 1'b1;
        @(negedge main_clock);
        rate_req  = 1'b0;
        wait_for(S_ACK, 1100, t_ack);
        check("ack_at_boundary", 32'(t_ack - t_fs2), 32'd1024);
        check("ack_with_frame_start", 32'(frame_start), 32'd1);
        check("busy_cleared_on_ack", 32'(busy), 32'd0);
        wait_for(S_RISE, 20, t_r1);
        check("first_rise_sel3", 32'(t_r1 - t_ack), 32'd4);
        wait_for(S_RISE, 20, t_r2);
        check("bclk_period_sel3", 32'(t_r2 - t_r1), 32'd8);
        tick(600);
        check("single_ack", 32'(ack_count), 32'd1);

        // Stop mid-frame: frame completes, then IDLE
        wait_for(S_FS, 600, t_fs);
        tick(20);
        enable = 1'b0;
        wait_for(S_IDLE, 600, t_idle);
        check("stop_at_boundary", 32'(t_idle - t_fs), 32'd512);
        check("stop_bclk_low", 32'(bclk), 32'd0);
        check("stop_lrck_low", 32'(lrck), 32'd0);
        check("stop_no_frame_start", 32'(frame_start), 32'd0);

        // Re-enable, brief drop of enable before the boundary: no gap
        enable = 1'b1;
        wait_for(S_RUN, 4, t_run);
        tick(100);
        enable = 1'b0;
        tick(50);
        enable = 1'b1;
        wait_for(S_FS, 600, t_fs2);
        check("resume_no_gap", 32'(t_fs2 - t_run), 32'd512);

        // Request in IDLE: ack the cycle after busy is seen
        enable = 1'b0;
        wait_for(S_IDLE, 600, t_idle);
        rate_sel = 2'd1;
        rate_req = 1'b1;
        @(negedge main_clock);
        rate_req = 1'b0;
        check("idle_busy", 32'(busy), 32'd1);
        @(negedge main_clock);
        check("idle_ack", 32'(rate_ack), 32'd1);
        check("idle_busy_clear", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_for(S_RUN, 4, t_run);
        wait_for(S_RISE, 40, t_r1);
        check("first_rise_sel1", 32'(t_r1 - t_run), 32'd12);
        wait_for(S_RISE, 40, t_r2);
        check("bclk_period_sel1", 32'(t_r2 - t_r1), 32'd24);

        // Reset at bit 40 with a request pending
        wait_for(S_FS, 3200, t_fs);
        tick(963);
        rate_sel = 2'd3;
        rate_req = 1'b1;
        @(negedge main_clock);
        rate_req = 1'b0;
        check("pending_before_reset", 32'(busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_v), 32'h0);
        @(negedge main_clock);
        reset = 1'b0;
        wait_for(S_RUN, 4, t_run);
        wait_for(S_RISE, 20, t_r1);
        check("post_reset_first_rise", 32'(t_r1 - t_run), 32'd8);
        wait_for(S_RISE, 20, t_r2);
        check("post_reset_period", 32'(t_r2 - t_r1), 32'd16);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
